// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner.
// Frame classification helper lives here.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } kp_frame_t;

  typedef struct packed {
    kp_frame_t  kind;
    logic [3:0] key;
  } kp_result_t;

  // Count set bits; remember the index of the last one found.
  function automatic kp_result_t kp_classify(
    input logic [NUM_KEYS-1:0] v
  );
    kp_result_t r;
    int n;
    r.kind = NONE;
    r.key  = '0;
    n      = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        n     = n + 1;
        r.key = 4'(i);
      end
    end
    if (n == 1) r.kind = SINGLE;
    else if (n > 1) r.kind = MULTI;
    return r;
  endfunction

endpackage

// File: rtl/keypad_column_scanner.sv
// Slot divider and rotating active-low column drive.
// Emits a sample strobe per slot and a frame_end strobe.
module keypad_column_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic [NUM_COLS-1:0] col_n_o,
  output logic [1:0]          col_o,
  output logic                sample_o,
  output logic                frame_end_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;

  assign sample_o    = (cnt_q == LAST);
  assign frame_end_o = sample_o && (col_q == 2'd3);
  assign col_o       = col_q;
  assign col_n_o     = ~(NUM_COLS'(1) << col_q);

  // Divider wraps at the slot end, stepping the column.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    col_d = col_q;
    if (sample_o) begin
      cnt_d = '0;
      col_d = col_q + 2'd1;
    end
  end

  // Divider and column registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      col_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: sync, frame snapshot, classify,
// and a frame-rate debounce FSM emitting key events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100_000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam int RW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [RW-1:0] RMAX = RW'(DEBOUNCE_FRAMES);
  localparam logic [RW-1:0] RONE = RW'(1);

  logic [1:0]          col;
  logic                sample;
  logic                frame_end;
  logic [NUM_ROWS-1:0] meta_q, sync_q;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [NUM_KEYS-1:0] live;
  kp_result_t          res;

  kp_state_t           state_q, state_d;
  logic [RW-1:0]       rcnt_q, rcnt_d, rinc;
  logic [3:0]          cand_q, cand_d;
  logic                accept, rel_done;

  logic [3:0]          code_q, code_d;
  logic                valid_q, valid_d;
  logic                held_q, held_d;
  logic                multi_q, multi_d;

  keypad_column_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk_i      (clk),
    .reset_i    (reset),
    .col_n_o    (col_n),
    .col_o      (col),
    .sample_o   (sample),
    .frame_end_o(frame_end)
  );

  // Two-flop row synchronizer, idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_n;
      sync_q <= meta_q;
    end
  end

  // Store the active column's pressed rows at slot end.
  always_comb begin
    snap_d = snap_q;
    if (sample) snap_d[col*NUM_ROWS +: NUM_ROWS] = ~sync_q;
  end

  // Last column is not stored yet at frame end; use it live.
  assign live = {~sync_q, snap_q[NUM_KEYS-NUM_ROWS-1:0]};
  assign res  = kp_classify(live);
  assign rinc = (rcnt_q == RMAX) ? rcnt_q : rcnt_q + 1'b1;

  // Debounce next-state: moves only at frame end.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    cand_d   = cand_q;
    accept   = 1'b0;
    rel_done = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (res.kind == SINGLE) begin
            cand_d  = res.key;
            rcnt_d  = RONE;
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (res.kind == SINGLE &&
              res.key == cand_q) begin
            rcnt_d = rinc;
            if (rinc == RMAX) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res.kind == NONE) begin
            rcnt_d  = RONE;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (res.kind == NONE) begin
            rcnt_d = rinc;
            if (rinc == RMAX) begin
              rel_done = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered key outputs derived from FSM events.
  always_comb begin
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    multi_d = multi_q;
    if (frame_end) multi_d = (res.kind == MULTI);
    if (accept) begin
      code_d  = cand_q;
      valid_d = 1'b1;
      held_d  = 1'b1;
    end
    if (rel_done) held_d = 1'b0;
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q  <= '0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_key = multi_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scanned 4x4 matrix keypad input controller: the input-side counterpart of the seven-segment digit multiplexing scan. It drives one keypad column low at a time in a rotating pattern and samples the four row lines. It debounces over whole scan frames and reports one accepted key code per press. It sits between the board keypad pins and the application logic that consumes key events.

## Interface
- SCAN_DIV, 100_000: clock cycles per column slot (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_FRAMES, 5: consecutive identical frames required to accept a press or a release; minimum 2.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- row_n  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
- col_n  output  4  column drive, active-low one-hot; exactly one bit is 0.
- key_code  output  4  last accepted key, col*4 + row; holds until the next acceptance.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  level, high while the accepted key is considered pressed.
- multi_key  output  1  level, high when the most recent frame saw two or more keys.

## Operation
- row_n passes through a 2-flop synchronizer to give row_sync. The synchronizer resets to 4'b1111.
- Divider cnt counts 0..SCAN_DIV-1 and wraps. Column index col counts 0..3 and wraps, advancing on the edge where cnt==SCAN_DIV-1. col_n = ~(1<<col).
- On each cnt==SCAN_DIV-1 edge, the 4 bits of ~row_sync are stored into snapshot[col*4 +: 4].
- Frame end is that edge with col==3. The frame result is computed from the 16-bit snapshot, with the current column's bits taken live:
  - NONE: 0 bits set.
  - SINGLE(k): 1 bit set; k is its index.
  - MULTI: 2 or more bits set.
- FSM advances only at frame end. rcnt is the frame counter.
  - IDLE:
    - SINGLE(k): cand=k, rcnt=1, go to CONFIRM.
    - NONE or MULTI: stay.
  - CONFIRM:
    - SINGLE(cand): rcnt++. When rcnt reaches DEBOUNCE_FRAMES, set key_code=cand, pulse key_valid, set key_held=1, go to HELD.
    - Any other result: go to IDLE.
  - HELD:
    - NONE: rcnt=1, go to RELEASE.
    - Any other result: stay. A second key or multi-press is ignored; there is no rollover.
  - RELEASE:
    - NONE: rcnt++. When rcnt reaches DEBOUNCE_FRAMES, set key_held=0 and go to IDLE.
    - Any other result: go to HELD with no new key_valid.
- multi_key is updated at every frame end: 1 if the result was MULTI, else 0.

## Timing
- Reset values:
  - col_n=4'b1110, cnt=0, col=0, snapshot=0.
  - state=IDLE, rcnt=0, cand=0.
  - key_code=0, key_valid=0, key_held=0, multi_key=0.
- Reset acts asynchronously mid-operation. All state returns to reset values with no clock edge, and a pending CONFIRM is discarded.
- col_n changes on the edge where cnt wraps to 0.
- Rows are sampled SCAN_DIV-1 edges later. This covers settling plus the 2-cycle synchronizer, which is why SCAN_DIV ≥ 4.
- One frame is 4*SCAN_DIV cycles.
- key_valid, key_held, key_code and multi_key are registered. They change on the frame-end edge; key_valid is high for exactly the following cycle.
- Minimum press-to-key_valid time is DEBOUNCE_FRAMES frames.
- Minimum release-to-key_held-low time is DEBOUNCE_FRAMES frames after the first empty frame.
- Counter widths: cnt is $clog2(SCAN_DIV); rcnt is $clog2(DEBOUNCE_FRAMES+1). rcnt saturates and never wraps.

## Structure
- Package keypad_pkg holds:
  - NUM_ROWS=4 and NUM_COLS=4.
  - State enum kp_state_t {IDLE, CONFIRM, HELD, RELEASE}.
  - Frame result enum kp_frame_t {NONE, SINGLE, MULTI}.
- Sub-module keypad_column_scanner contains the divider, the column rotation (col_n plus the 2-bit col index) and the sample/frame_end strobes.
- The top level holds the synchronizer, snapshot, frame classification and FSM.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3, so one frame is 16 cycles. The bench models a matrix: row_n[r]=0 when the key at (active column, r) is pressed.
- Reset release, no keys:
  - col_n is 1110 and all outputs are 0.
  - col_n steps 1101, 1011, 0111, 1110 at edges 4, 8, 12, 16.
  - No key_valid appears in 10 frames.
- Press key 6 (col 1, row 2) and hold:
  - Exactly one key_valid pulse, at the 3rd frame end after the press.
  - key_code=6 and key_held=1 from then on.
- Bounce: key 6 pressed for 1 frame only, then released:
  - No key_valid; FSM returns to IDLE; key_code keeps its previous value.
- Keys 6 and 11 pressed together:
  - multi_key=1 after the first frame end.
  - No key_valid; multi_key=0 one frame after the release.
- Release behaviour while key 6 is held:
  - A 1-frame release then re-press keeps key_held=1 with no second key_valid.
  - A full release drops key_held 3 frames after the first empty frame.
- Assert reset mid-CONFIRM, asynchronously between edges:
  - Outputs and col_n go to their reset values immediately.
  - After deassertion, a full 3 frames are needed before key_valid.
